bmem_line_arbiter: RTL and testbench

Line-granular memory front end between the mp4 core's caches and the burst memory port. It arbitrates among three line requesters: dcache (read/write), icache (read) and the instruction prefetcher (read). It serializes each 256-bit line into 64-bit bursts on the bmem port and reassembles read bursts into a full line. Its bmem-side ports connect directly to the top-level bmem_address/read/write/rdata/wdata/resp pins.

---
 rtl/bmem_line_arbiter.sv | 145 ++++++++++++++
 tb/tb_bmem_line_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_line_arbiter.sv
// Three-client line arbiter (dcache > icache > prefetch) that serializes 256-bit
// lines into 64-bit bmem bursts and reassembles read bursts into full lines.
module bmem_line_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              pf_read,
    input  logic [ADDR_W-1:0] pf_addr,
    output logic [LINE_W-1:0] pf_rdata,
    output logic              pf_resp,
    output logic [ADDR_W-1:0] bmem_address,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_resp,
    output logic              busy
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

    typedef enum logic [2:0] {IDLE, RD_CMD, RD_BEAT, WR_BEAT, WR_WAIT, DONE} state_t;
    typedef enum logic [1:0] {CL_D, CL_I, CL_PF} client_t;

    state_t            state, state_n;
    client_t           client, grant_client;
    logic              grant;
    logic [ADDR_W-1:0] grant_addr;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] line, line_fill;
    logic [LINE_W-1:0] d_rdata_q, i_rdata_q, pf_rdata_q;
    logic              last;

    assign last = (cnt == LAST_BEAT);

    always_comb begin
        state_n      = state;
        grant        = 1'b0;
        grant_client = CL_D;
        grant_addr   = d_addr;
        case (state)
            IDLE: begin
                if (d_read || d_write) begin
                    grant        = 1'b1;
                    grant_client = CL_D;
                    grant_addr   = d_addr;
                    state_n      = d_write ? WR_BEAT : RD_CMD;
                end else if (i_read) begin
                    grant        = 1'b1;
                    grant_client = CL_I;
                    grant_addr   = i_addr;
                    state_n      = RD_CMD;
                end else if (pf_read) begin
                    grant        = 1'b1;
                    grant_client = CL_PF;
                    grant_addr   = pf_addr;
                    state_n      = RD_CMD;
                end
            end
            RD_CMD:  state_n = RD_BEAT;
            RD_BEAT: if (bmem_resp && last) state_n = DONE;
            WR_BEAT: if (last) state_n = WR_WAIT;
            WR_WAIT: if (bmem_resp) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Current line with the incoming beat merged in; also the completed line on the last beat.
    always_comb begin
        line_fill = line;
        line_fill[int'(cnt)*BEAT_W +: BEAT_W] = bmem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            client     <= CL_D;
            cnt        <= '0;
            addr_q     <= '0;
            line       <= '0;
            d_rdata_q  <= '0;
            i_rdata_q  <= '0;
            pf_rdata_q <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (grant) begin
                        client <= grant_client;
                        addr_q <= grant_addr & LINE_MASK;
                        cnt    <= '0;
                        if (grant_client == CL_D && d_write) line <= d_wdata;
                    end
                end
                RD_CMD: cnt <= '0;
                RD_BEAT: begin
                    if (bmem_resp) begin
                        line <= line_fill;
                        cnt  <= cnt + 1'b1;
                        if (last) begin
                            case (client)
                                CL_D:    d_rdata_q  <= line_fill;
                                CL_I:    i_rdata_q  <= line_fill;
                                default: pf_rdata_q <= line_fill;
                            endcase
                        end
                    end
                end
                WR_BEAT: cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign bmem_read    = (state == RD_CMD);
    assign bmem_write   = (state == WR_BEAT);
    assign bmem_address = addr_q;
    assign bmem_wdata   = (state == WR_BEAT) ? line[int'(cnt)*BEAT_W +: BEAT_W] : '0;
    assign d_resp       = (state == DONE) && (client == CL_D);
    assign i_resp       = (state == DONE) && (client == CL_I);
    assign pf_resp      = (state == DONE) && (client == CL_PF);
    assign d_rdata      = d_rdata_q;
    assign i_rdata      = i_rdata_q;
    assign pf_rdata     = pf_rdata_q;

endmodule

// File: tb/tb_bmem_line_arbiter.sv
// Directed bench for bmem_line_arbiter: the bench plays the bmem side cycle by cycle
// and checks each client transaction against hand-computed values.
module tb_bmem_line_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         d_read, d_write, i_read, pf_read;
    logic [31:0]  d_addr, i_addr, pf_addr;
    logic [255:0] d_wdata, d_rdata, i_rdata, pf_rdata;
    logic         d_resp, i_resp, pf_resp;
    logic [31:0]  bmem_address;
    logic         bmem_read, bmem_write, bmem_resp, busy;
    logic [63:0]  bmem_wdata, bmem_rdata;

    int checks = 0;
    int errors = 0;

    bmem_line_arbiter #(.ADDR_W(32), .LINE_W(256), .BEAT_W(64)) dut (
        .clk(clk), .rst(rst),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .pf_read(pf_read), .pf_addr(pf_addr), .pf_rdata(pf_rdata), .pf_resp(pf_resp),
        .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns a line beat by beat; optional idle gap after the first beat.
    task automatic serve_read(input logic [255:0] line, input int gap);
        for (int k = 0; k < 4; k++) begin
            bmem_rdata = line[k*64 +: 64];
            bmem_resp  = 1'b1;
            tick();
            bmem_resp  = 1'b0;
            bmem_rdata = '0;
            if (k == 0) repeat (gap) tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        d_read = 0; d_write = 0; i_read = 0; pf_read = 0;
        d_addr = '0; i_addr = '0; pf_addr = '0; d_wdata = '0;
        bmem_resp = 0; bmem_rdata = '0;
        #2;
        checks++;
        if ({busy, bmem_read, bmem_write, d_resp, i_resp, pf_resp} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl got busy=%b rd=%b wr=%b resp=%b%b%b want all 0",
                     busy, bmem_read, bmem_write, d_resp, i_resp, pf_resp);
        end
        checks++;
        if (bmem_address !== 32'h0 || bmem_wdata !== 64'h0 || d_rdata !== '0 ||
            i_rdata !== '0 || pf_rdata !== '0) begin
            errors++;
            $display("FAIL reset_data got addr=%h wdata=%h want 0 (rdata also 0)",
                     bmem_address, bmem_wdata);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_icache_read();
        logic [255:0] li;
        li = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        i_addr = 32'h0000_1064;
        i_read = 1'b1;
        tick();
        checks++;
        if (bmem_read !== 1'b1 || bmem_address !== 32'h0000_1060 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ird_cmd got rd=%b addr=%h busy=%b want 1 00001060 1",
                     bmem_read, bmem_address, busy);
        end
        tick();
        checks++;
        if (bmem_read !== 1'b0) begin
            errors++;
            $display("FAIL ird_one_pulse got rd=%b want 0", bmem_read);
        end
        serve_read(li, 2);
        checks++;
        if (i_resp !== 1'b1 || d_resp !== 1'b0 || pf_resp !== 1'b0) begin
            errors++;
            $display("FAIL ird_resp got d=%b i=%b pf=%b want 0 1 0", d_resp, i_resp, pf_resp);
        end
        checks++;
        if (i_rdata !== li) begin
            errors++;
            $display("FAIL ird_data got %h want %h", i_rdata, li);
        end
        i_read = 1'b0;
        tick();
        checks++;
        if (i_resp !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ird_after got resp=%b busy=%b want 0 0", i_resp, busy);
        end
    endtask

    task automatic test_dcache_write();
        logic [255:0] lw;
        lw = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
              64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
        d_addr  = 32'h8000_0040;
        d_wdata = lw;
        d_write = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bmem_write !== 1'b1 || bmem_wdata !== lw[k*64 +: 64] ||
                bmem_address !== 32'h8000_0040) begin
                errors++;
                $display("FAIL wr_beat%0d got wr=%b wdata=%h addr=%h want 1 %h 80000040",
                         k, bmem_write, bmem_wdata, bmem_address, lw[k*64 +: 64]);
            end
            tick();
        end
        checks++;
        if (bmem_write !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wr_four_only got wr=%b busy=%b want 0 1", bmem_write, busy);
        end
        repeat (4) tick();
        checks++;
        if (d_resp !== 1'b0) begin
            errors++;
            $display("FAIL wr_wait got d_resp=%b want 0", d_resp);
        end
        bmem_resp = 1'b1;
        tick();
        bmem_resp = 1'b0;
        checks++;
        if (d_resp !== 1'b1) begin
            errors++;
            $display("FAIL wr_resp got d_resp=%b want 1", d_resp);
        end
        d_write = 1'b0;
        tick();
        checks++;
        if (d_resp !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_after got d_resp=%b busy=%b want 0 0", d_resp, busy);
        end
    endtask

    task automatic test_priority();
        logic [255:0] ld, li, lp;
        ld = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
        li = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
        lp = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
        d_addr = 32'h0000_0100; i_addr = 32'h0000_2013; pf_addr = 32'h0000_305F;
        d_read = 1'b1; i_read = 1'b1; pf_read = 1'b1;
        tick();
        checks++;
        if (bmem_read !== 1'b1 || bmem_address !== 32'h0000_0100) begin
            errors++;
            $display("FAIL pri_d_first got rd=%b addr=%h want 1 00000100", bmem_read, bmem_address);
        end
        tick();
        serve_read(ld, 0);
        checks++;
        if (d_resp !== 1'b1 || i_resp !== 1'b0 || pf_resp !== 1'b0 || d_rdata !== ld) begin
            errors++;
            $display("FAIL pri_d_done got resp=%b%b%b data=%h want 100 %h",
                     d_resp, i_resp, pf_resp, d_rdata, ld);
        end
        d_read = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || bmem_read !== 1'b0) begin
            errors++;
            $display("FAIL pri_gap got busy=%b rd=%b want 0 0", busy, bmem_read);
        end
        tick();
        checks++;
        if (bmem_read !== 1'b1 || bmem_address !== 32'h0000_2000) begin
            errors++;
            $display("FAIL pri_i_second got rd=%b addr=%h want 1 00002000", bmem_read, bmem_address);
        end
        tick();
        serve_read(li, 0);
        checks++;
        if (i_resp !== 1'b1 || d_resp !== 1'b0 || pf_resp !== 1'b0 || i_rdata !== li) begin
            errors++;
            $display("FAIL pri_i_done got resp=%b%b%b data=%h want 010 %h",
                     d_resp, i_resp, pf_resp, i_rdata, li);
        end
        i_read = 1'b0;
        tick();
        tick();
        checks++;
        if (bmem_read !== 1'b1 || bmem_address !== 32'h0000_3040) begin
            errors++;
            $display("FAIL pri_pf_third got rd=%b addr=%h want 1 00003040", bmem_read, bmem_address);
        end
        tick();
        serve_read(lp, 0);
        checks++;
        if (pf_resp !== 1'b1 || pf_rdata !== lp || d_rdata !== ld || i_rdata !== li) begin
            errors++;
            $display("FAIL pri_pf_done got resp=%b pf=%h d=%h i=%h want 1 %h %h %h",
                     pf_resp, pf_rdata, d_rdata, i_rdata, lp, ld, li);
        end
        pf_read = 1'b0;
        tick();
    endtask

    task automatic test_pf_drop();
        logic [255:0] lp, li;
        lp = {64'hF3, 64'hF2, 64'hF1, 64'hF0};
        li = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
        pf_addr = 32'h0000_4000;
        pf_read = 1'b1;
        tick();
        pf_read = 1'b0;
        tick();
        i_addr = 32'h0000_5000;
        i_read = 1'b1;
        serve_read(lp, 1);
        checks++;
        if (pf_resp !== 1'b1 || i_resp !== 1'b0 || pf_rdata !== lp) begin
            errors++;
            $display("FAIL pfdrop_done got pf=%b i=%b data=%h want 1 0 %h",
                     pf_resp, i_resp, pf_rdata, lp);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || bmem_read !== 1'b0) begin
            errors++;
            $display("FAIL pfdrop_idle got busy=%b rd=%b want 0 0", busy, bmem_read);
        end
        tick();
        checks++;
        if (bmem_read !== 1'b1 || bmem_address !== 32'h0000_5000) begin
            errors++;
            $display("FAIL pfdrop_i_grant got rd=%b addr=%h want 1 00005000", bmem_read, bmem_address);
        end
        tick();
        serve_read(li, 0);
        checks++;
        if (i_resp !== 1'b1 || i_rdata !== li) begin
            errors++;
            $display("FAIL pfdrop_i_done got resp=%b data=%h want 1 %h", i_resp, i_rdata, li);
        end
        i_read = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [255:0] li;
        li = {64'h9A9A_0003, 64'h9A9A_0002, 64'h9A9A_0001, 64'h9A9A_0000};
        i_addr = 32'h0000_6000;
        i_read = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            bmem_rdata = 64'hDEAD_0000 + 64'(k);
            bmem_resp  = 1'b1;
            tick();
        end
        bmem_resp  = 1'b0;
        bmem_rdata = '0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || bmem_read !== 1'b0 || i_resp !== 1'b0 ||
            bmem_address !== 32'h0 || i_rdata !== '0) begin
            errors++;
            $display("FAIL rstmid_async got busy=%b rd=%b resp=%b addr=%h want 0 0 0 0 (rdata 0)",
                     busy, bmem_read, i_resp, bmem_address);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bmem_read !== 1'b1 || bmem_address !== 32'h0000_6000 || i_resp !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_regrant got rd=%b addr=%h resp=%b want 1 00006000 0",
                     bmem_read, bmem_address, i_resp);
        end
        tick();
        serve_read(li, 0);
        checks++;
        if (i_resp !== 1'b1 || i_rdata !== li) begin
            errors++;
            $display("FAIL rstmid_line got resp=%b data=%h want 1 %h", i_resp, i_rdata, li);
        end
        i_read = 1'b0;
        tick();
    endtask

    task automatic test_spurious_resp();
        bmem_rdata = 64'h5555_5555_5555_5555;
        bmem_resp  = 1'b1;
        tick();
        bmem_resp  = 1'b0;
        bmem_rdata = '0;
        checks++;
        if (busy !== 1'b0 || {d_resp, i_resp, pf_resp} !== 3'b000) begin
            errors++;
            $display("FAIL spur_idle got busy=%b resp=%b%b%b want 0 000",
                     busy, d_resp, i_resp, pf_resp);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || {d_resp, i_resp, pf_resp} !== 3'b000 || bmem_read !== 1'b0) begin
            errors++;
            $display("FAIL spur_after got busy=%b resp=%b%b%b rd=%b want 0 000 0",
                     busy, d_resp, i_resp, pf_resp, bmem_read);
        end
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_priority();
        test_pf_drop();
        test_reset_mid();
        test_spurious_resp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
